// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a synchronous ROM one word per
// cycle and feeds decode from a 2-entry prefetch queue with stall/redirect handling.
module fetch_unit #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   output logic                  IMEM_REQ,
   output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
   input  logic [31:0]           IMEM_RDATA,
   input  logic                  STALL,
   input  logic                  REDIRECT_VALID,
   input  logic [31:0]           REDIRECT_PC,
   output logic [31:0]           INSTRUCTION,
   output logic [31:0]           INSTRUCTION_PC,
   output logic                  INSTRUCTION_VALID,
   output logic                  FETCH_FAULT
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] word_q [2];
   logic [31:0] word_d [2];
   logic [31:0] qpc_q  [2];
   logic [31:0] qpc_d  [2];
   logic [1:0]  count_q, count_d;
   logic        head_q, head_d;
   logic        inflight_q, inflight_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   logic [31:0] last_pc_q, last_pc_d;

   logic        run;
   logic        pop;
   logic        push;
   logic        wr_idx;
   logic [2:0]  occ;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q       <= ST_RUN;
         pc_q          <= RESET_PC;
         word_q        <= '{default: '0};
         qpc_q         <= '{default: '0};
         count_q       <= '0;
         head_q        <= 1'b0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         last_pc_q     <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         word_q        <= word_d;
         qpc_q         <= qpc_d;
         count_q       <= count_d;
         head_q        <= head_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         last_pc_q     <= last_pc_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      word_d        = word_q;
      qpc_d         = qpc_q;
      count_d       = count_q;
      head_d        = head_q;
      inflight_pc_d = inflight_pc_q;
      last_pc_d     = last_pc_q;

      run               = (state_q == ST_RUN);
      INSTRUCTION_VALID = (count_q != 2'd0) && run;
      INSTRUCTION       = INSTRUCTION_VALID ? word_q[head_q] : NOP_INSTR;
      INSTRUCTION_PC    = (count_q != 2'd0) ? qpc_q[head_q] : last_pc_q;
      FETCH_FAULT       = (state_q == ST_HALT);
      IMEM_ADDR         = pc_q[ADDR_WIDTH+1:2];

      // occupancy counts the in-flight word so the queue can never overflow
      occ      = {1'b0, count_q} + {2'b00, inflight_q};
      pop      = INSTRUCTION_VALID && !STALL && !REDIRECT_VALID;
      IMEM_REQ = RST_N && run && !REDIRECT_VALID && (occ < ({2'b00, pop} + 3'd2));
      push     = inflight_q && !REDIRECT_VALID;
      wr_idx   = head_q ^ (count_q == 2'd1);

      inflight_d = IMEM_REQ;
      if (IMEM_REQ) inflight_pc_d = pc_q;
      if (count_q != 2'd0) last_pc_d = qpc_q[head_q];

      // data returning in a redirect cycle is simply never pushed
      if (REDIRECT_VALID && run) begin
         count_d = '0;
         head_d  = 1'b0;
         pc_d    = {REDIRECT_PC[31:2], 2'b00};
         if (REDIRECT_PC[1:0] != 2'b00) state_d = ST_HALT;
      end else begin
         if (push) begin
            word_d[wr_idx] = IMEM_RDATA;
            qpc_d[wr_idx]  = inflight_pc_q;
         end
         if (pop) head_d = ~head_q;
         count_d = count_q + {1'b0, push} - {1'b0, pop};
         if (IMEM_REQ) pc_d = pc_q + 32'd4;
      end
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the CPU decode/execute datapath.
- Owns the program counter and issues word reads to a synchronous instruction ROM.
- Buffers returned words in a 2-entry prefetch queue and presents INSTRUCTION / INSTRUCTION_PC to decode.
- Handles decode stalls and branch/jump redirects from execute; halts on a misaligned redirect target.

Parameters:
ADDR_WIDTH, 10, width of the instruction word index driven to the ROM
RESET_PC, 32'h00000000, byte address fetched first after reset
NOP_INSTR, 32'h00000013, word driven on INSTRUCTION when INSTRUCTION_VALID=0 (addi x0,x0,0)

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
IMEM_REQ  out  1  ROM read enable for this cycle
IMEM_ADDR  out  ADDR_WIDTH  word index = PC[ADDR_WIDTH+1:2]
IMEM_RDATA  in  32  ROM data, valid exactly one cycle after IMEM_REQ=1
STALL  in  1  decode cannot accept the presented instruction this cycle
REDIRECT_VALID  in  1  execute resolved taken branch/JAL/JALR
REDIRECT_PC  in  32  redirect byte target
INSTRUCTION  out  32  instruction to decode
INSTRUCTION_PC  out  32  byte address of INSTRUCTION
INSTRUCTION_VALID  out  1  INSTRUCTION is a real fetched word
FETCH_FAULT  out  1  misaligned redirect seen; fetch halted

Behaviour:
- Reset (RST_N=0, async): PC=RESET_PC, queue empty, no read in flight, state=RUN, FETCH_FAULT=0.
  - Outputs during reset: IMEM_REQ=0, INSTRUCTION_VALID=0, INSTRUCTION=NOP_INSTR, INSTRUCTION_PC=0.
  - Reset mid-operation discards queue contents and any in-flight read.
- States: RUN, HALT. HALT is left only by reset.
- Queue: 2 entries of {word, pc}. Head is presented on INSTRUCTION/INSTRUCTION_PC; INSTRUCTION_VALID = queue non-empty and state=RUN.
  - When the queue is empty, INSTRUCTION=NOP_INSTR and INSTRUCTION_PC holds its last value.
- Pop: the head is popped on the rising edge when INSTRUCTION_VALID=1 and STALL=0.
- Request rule: IMEM_REQ=1 iff state=RUN, REDIRECT_VALID=0, and (count + inflight - pop) < 2.
  - On an accepted request, PC advances by 4, wrapping modulo 2^32; the ROM index wraps naturally at 2^ADDR_WIDTH words.
  - The pc of the issued word is recorded with the in-flight flag.
- Response: the cycle after a request, IMEM_RDATA is written to the queue tail with its recorded pc, unless it is discarded (see redirect).
  - The request rule guarantees the queue is never written while full.
  - Simultaneous push and pop in the same cycle is legal; count is unchanged.
- Redirect (REDIRECT_VALID=1) has priority over STALL, pop, and request.
  - Queue is flushed; no pop occurs that cycle.
  - Any in-flight response is marked discard and dropped the next cycle.
  - PC <= REDIRECT_PC; IMEM_REQ=0 that cycle.
- Redirect to refetch valid timing:
  - Cycle R: redirect.
  - Cycle R+1: IMEM_REQ=1, address = target.
  - Cycle R+2: data returns.
  - Cycle R+3: INSTRUCTION_VALID=1 with INSTRUCTION_PC = target.
- Misaligned redirect (REDIRECT_PC[1:0] != 0):
  - Enter HALT; FETCH_FAULT=1, sticky until reset.
  - Queue flushed; no further IMEM_REQ; INSTRUCTION_VALID=0.
  - PC <= REDIRECT_PC & ~3.
- First fetch after reset release: IMEM_REQ=1 with IMEM_ADDR = RESET_PC word index in the first cycle; INSTRUCTION_VALID=1 two cycles later.
- Throughput: with STALL=0 continuously, one instruction per cycle is sustained with no bubbles after the initial fill.
- STALL held with the queue full: IMEM_REQ=0 and PC frozen; the head stays stable on the outputs.

Test Plan:
- Reset release, STALL=0, ROM[i]=i+1 → IMEM_ADDR 0,1,2,… one per cycle; INSTRUCTION_VALID rises 2 cycles after the first request; INSTRUCTION 1,2,3,… with INSTRUCTION_PC 0,4,8,…, no gaps.
- STALL=1 for 5 cycles after the second valid word → queue fills to 2; IMEM_REQ=0 afterwards; INSTRUCTION/PC held at word 2 / PC 4. On STALL release, words 2,3,4 are presented in order with none lost or duplicated.
- REDIRECT_VALID=1 with REDIRECT_PC=0x40 while the queue is full and a read is in flight → both queued words and the in-flight word are dropped; IMEM_ADDR=0x10 on the next cycle; first valid INSTRUCTION_PC=0x40 exactly 3 cycles after the redirect.
- Redirect asserted in the same cycle as STALL=0 with valid head → no pop is counted; redirect wins; no stale instruction appears afterwards.
- REDIRECT_PC=0x42 → FETCH_FAULT=1 next cycle and stays 1; IMEM_REQ stays 0 and INSTRUCTION_VALID stays 0 until RST_N pulse; after reset, FETCH_FAULT=0 and fetch restarts at RESET_PC.
- Redirect to 0xFFC with ADDR_WIDTH=10, STALL=0 → IMEM_ADDR 0x3FF then 0x000; INSTRUCTION_PC 0xFFC then 0x1000. Async RST_N low mid-stream → IMEM_REQ and INSTRUCTION_VALID drop to 0 immediately, without waiting for a clock edge.
